// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the multi-channel AES request scheduler.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int unsigned BLK_W = 128;

    // Ceiling log2 that never returns less than 1, so one-channel builds keep a real bus.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/aes_req_fifo.sv
// Per-channel request FIFO: synchronous, full/empty from pointers with one wrap bit.
module aes_req_fifo #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/aes_multi_ch_sched.sv
// Round-robin scheduler feeding one AES core from NUM_CH request FIFOs, with a watchdog.
module aes_multi_ch_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CORE_TIMEOUT = 64,
    parameter int unsigned CH_W         = clog2_min1(NUM_CH)
) (
    input  logic                    AES_clk,
    input  logic                    AES_rst_n,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH*BLK_W-1:0] req_data,
    input  logic [NUM_CH*BLK_W-1:0] req_key,
    output logic                    core_en,
    output logic [BLK_W-1:0]        core_data_in,
    output logic [BLK_W-1:0]        core_key_in,
    input  logic                    core_data_out_valid,
    input  logic [BLK_W-1:0]        core_data_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [BLK_W-1:0]        res_data,
    output logic [CH_W-1:0]         res_ch,
    output logic                    res_timeout,
    output logic                    busy
);

    localparam int unsigned CNT_W = clog2_min1(CORE_TIMEOUT);

    state_t                 state;
    logic [CH_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_CH-1:0]      full;
    logic [NUM_CH-1:0]      empty;
    logic [NUM_CH-1:0]      pop;
    logic [2*BLK_W-1:0]     head [NUM_CH];
    logic [CH_W-1:0]        grant;
    logic                   grant_vld;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
        aes_req_fifo #(
            .WIDTH (2*BLK_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (AES_clk),
            .rst_n (AES_rst_n),
            .push  (req_valid[gi] & ~full[gi]),
            .din   ({req_key[gi*BLK_W +: BLK_W], req_data[gi*BLK_W +: BLK_W]}),
            .pop   (pop[gi]),
            .dout  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
        );
    end

    assign req_ready = ~full;

    // First non-empty channel at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (!grant_vld && !empty[idx[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pop[i] = (state == ST_IDLE) && grant_vld && (grant == CH_W'(i));
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            cnt          <= '0;
            core_en      <= 1'b0;
            core_data_in <= '0;
            core_key_in  <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_ch       <= '0;
            res_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            core_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        {core_key_in, core_data_in} <= head[grant];
                        res_ch  <= grant;
                        rr_ptr  <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
                        core_en <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A core result arriving on the expiry cycle still wins over the timeout.
                    if (core_data_out_valid) begin
                        res_data    <= core_data_out;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (cnt == CNT_W'(CORE_TIMEOUT-1)) begin
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
